// File: rtl/cache_arbiter.sv
// Purpose: grants the single pmem port to one of the I-cache or D-cache line requests, round-robin on ties.
// Latency: grant strobes and latched address/data appear one cycle after a request is seen in IDLE; resp is routed combinationally.
// Backpressure: requesters hold their level request until their own resp; the losing side simply waits in IDLE arbitration.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic         i_pmem_resp,
    output logic [255:0] i_pmem_rdata,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic         d_pmem_resp,
    output logic [255:0] d_pmem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_RD   = 2'd2,
        D_WR   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;  // 0: I granted last, 1: D granted last
    logic           pmem_read_q, pmem_write_q;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wdata_q, wdata_d;

    logic           i_req;
    logic           d_req;
    logic           pick_d;

    assign i_req  = i_pmem_read;
    assign d_req  = d_pmem_read | d_pmem_write;
    // D wins when it is alone, or on a tie when I was the last one served.
    assign pick_d = d_req & (~i_req | ~last_grant_q);

    // Arbitration in IDLE, completion tracking in the busy states.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    // A simultaneous read+write from D is illegal; the write takes precedence.
                    state_d      = d_pmem_write ? D_WR : D_RD;
                    last_grant_d = 1'b1;
                    addr_d       = d_pmem_address;
                    if (d_pmem_write) begin
                        wdata_d = d_pmem_wdata;
                    end
                end else if (i_req) begin
                    state_d      = I_BUSY;
                    last_grant_d = 1'b0;
                    addr_d       = i_pmem_address;
                end
            end
            default: begin
                // Requester inputs are ignored until memory completes.
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, grant history, and registered memory-side strobes/payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 256'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pmem_read_q  <= (state_d == I_BUSY) || (state_d == D_RD);
            pmem_write_q <= (state_d == D_WR);
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // A resp landing in a reset cycle belongs to a transfer being abandoned, so it is suppressed.
    assign i_pmem_resp  = rst_n & pmem_resp & (state_q == I_BUSY);
    assign d_pmem_resp  = rst_n & pmem_resp & ((state_q == D_RD) || (state_q == D_WR));
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Purpose: checks cache_arbiter against a transaction-level ownership model plus directed literal expectations.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_pmem_read = 1'b0;
    logic [31:0]  i_pmem_address = 32'd0;
    logic         i_pmem_resp;
    logic [255:0] i_pmem_rdata;
    logic         d_pmem_read = 1'b0;
    logic         d_pmem_write = 1'b0;
    logic [31:0]  d_pmem_address = 32'd0;
    logic [255:0] d_pmem_wdata = 256'd0;
    logic         d_pmem_resp;
    logic [255:0] d_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp = 1'b0;
    logic [255:0] pmem_rdata = 256'd0;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model: who owns memory (0 nobody, 1 I, 2 D), what was latched, who was served last.
    int           m_owner = 0;
    bit           m_last_d = 1'b1;
    bit           m_rd = 1'b0;
    bit           m_wr = 1'b0;
    logic [31:0]  m_addr = 32'd0;
    logic [255:0] m_wdata = 256'd0;
    bit           m_ir, m_dr;

    always @(posedge clk) begin
        m_ir = i_pmem_read;
        m_dr = d_pmem_read | d_pmem_write;
        if (!rst_n) begin
            m_owner = 0; m_last_d = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
            m_addr = 32'd0; m_wdata = 256'd0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_owner = 0; m_rd = 1'b0; m_wr = 1'b0;
            end
        end else if (m_ir && (!m_dr || m_last_d)) begin
            m_owner = 1; m_last_d = 1'b0; m_addr = i_pmem_address; m_rd = 1'b1; m_wr = 1'b0;
        end else if (m_dr) begin
            m_owner = 2; m_last_d = 1'b1; m_addr = d_pmem_address;
            if (d_pmem_write) begin
                m_wdata = d_pmem_wdata; m_wr = 1'b1; m_rd = 1'b0;
            end else begin
                m_rd = 1'b1; m_wr = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        check("m.pmem_read",    pmem_read,    m_rd);
        check("m.pmem_write",   pmem_write,   m_wr);
        check("m.pmem_address", pmem_address, m_addr);
        check("m.pmem_wdata",   pmem_wdata,   m_wdata);
        check("m.i_pmem_resp",  i_pmem_resp,  rst_n && pmem_resp && (m_owner == 1));
        check("m.d_pmem_resp",  d_pmem_resp,  rst_n && pmem_resp && (m_owner == 2));
        check("m.i_pmem_rdata", i_pmem_rdata, pmem_rdata);
        check("m.d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    end

    // Response log: 1 = I resp, 2 = D resp, in arrival order.
    int order[$];
    int cnt_i = 0;
    int cnt_d = 0;
    always @(negedge clk) begin
        if (i_pmem_resp === 1'b1) begin cnt_i++; order.push_back(1); end
        if (d_pmem_resp === 1'b1) begin cnt_d++; order.push_back(2); end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int ci, cd;
        bit s, r, si, sd;
        int mcnt;
        int k;
        int exp4[4];
        exp4 = '{1, 2, 1, 2};

        // Reset, then a single I read answered three cycles after its strobe.
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst pmem_read",    pmem_read,    0);
        check("rst pmem_write",   pmem_write,   0);
        check("rst pmem_address", pmem_address, 0);
        check("rst pmem_wdata",   pmem_wdata,   0);
        check("rst i_pmem_resp",  i_pmem_resp,  0);
        check("rst d_pmem_resp",  d_pmem_resp,  0);
        tick();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
        @(negedge clk);
        check("t1 no strobe yet", pmem_read, 0);
        tick();
        @(negedge clk);
        check("t1 pmem_read", pmem_read, 1);
        check("t1 pmem_address", pmem_address, 32'h0000_1000);
        tick(); tick(); tick();
        pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}};
        @(negedge clk);
        check("t1 i_pmem_resp", i_pmem_resp, 1);
        check("t1 i_pmem_rdata", i_pmem_rdata, {32{8'hA5}});
        check("t1 d_pmem_resp", d_pmem_resp, 0);
        tick();
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);
        check("t1 strobe dropped", pmem_read, 0);
        check("t1 no d resp total", cnt_d, 0);

        // Simultaneous I read and D write straight out of reset: I first.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = {8{32'hDEADBEEF}};
        tick();
        @(negedge clk);
        check("t2 I read first", pmem_read, 1);
        check("t2 no write yet", pmem_write, 0);
        check("t2 I addr", pmem_address, 32'h100);
        tick();
        pmem_resp = 1'b1; pmem_rdata = rnd256();
        @(negedge clk);
        check("t2 i resp", i_pmem_resp, 1);
        check("t2 d no resp", d_pmem_resp, 0);
        tick();
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);
        check("t2 gap read", pmem_read, 0);
        check("t2 gap write", pmem_write, 0);
        tick();
        @(negedge clk);
        check("t2 D write", pmem_write, 1);
        check("t2 D addr", pmem_address, 32'h200);
        check("t2 D wdata", pmem_wdata, {8{32'hDEADBEEF}});
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        check("t2 d resp", d_pmem_resp, 1);
        tick();
        pmem_resp = 1'b0;

        // Writeback then refill issued the cycle after the write completes.
        d_pmem_write = 1'b1; d_pmem_address = 32'h300; d_pmem_wdata = rnd256();
        tick();
        @(negedge clk);
        check("t3 write strobe", pmem_write, 1);
        check("t3 write addr", pmem_address, 32'h300);
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        check("t3 wb resp", d_pmem_resp, 1);
        tick();
        pmem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h400;
        @(negedge clk);
        check("t3 gap", pmem_read | pmem_write, 0);
        tick();
        @(negedge clk);
        check("t3 refill read", pmem_read, 1);
        check("t3 refill addr", pmem_address, 32'h400);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; d_pmem_read = 1'b0;

        // Continuous contention: four transfers must alternate I, D, I, D.
        base = order.size(); ci = cnt_i; cd = cnt_d;
        i_pmem_read = 1'b1; i_pmem_address = 32'h700;
        d_pmem_read = 1'b1; d_pmem_address = 32'h800;
        for (int n = 0; n < 60 && (order.size() - base) < 4; n++) begin
            @(negedge clk);
            s = pmem_read | pmem_write; r = pmem_resp;
            tick();
            pmem_resp = s && !r;
        end
        pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        check("t4 transfers done", order.size() - base, 4);
        for (int n = 0; n < 4 && (base + n) < order.size(); n++)
            check($sformatf("t4 grant %0d", n), order[base + n], exp4[n]);
        check("t4 I resps", cnt_i - ci, 2);
        check("t4 D resps", cnt_d - cd, 2);

        // Requester inputs change after the grant; latched values must hold.
        tick();
        d_pmem_write = 1'b1; d_pmem_address = 32'h500; d_pmem_wdata = {8{32'h12345678}};
        tick();
        @(negedge clk);
        check("t5 write", pmem_write, 1);
        check("t5 addr", pmem_address, 32'h500);
        tick();
        d_pmem_address = 32'h999; d_pmem_wdata = ~{8{32'h12345678}};
        @(negedge clk);
        check("t5 addr held", pmem_address, 32'h500);
        check("t5 wdata held", pmem_wdata, {8{32'h12345678}});
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        check("t5 addr held at resp", pmem_address, 32'h500);
        check("t5 resp", d_pmem_resp, 1);
        tick();
        pmem_resp = 1'b0; d_pmem_write = 1'b0;

        // Reset mid-transfer with pmem_resp in the reset cycle.
        i_pmem_read = 1'b1; i_pmem_address = 32'h600;
        tick();
        @(negedge clk);
        check("t6 busy", pmem_read, 1);
        tick();
        rst_n = 1'b0; pmem_resp = 1'b1;
        @(negedge clk);
        check("t6 resp suppressed", i_pmem_resp, 0);
        tick();
        rst_n = 1'b1; pmem_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);
        check("t6 strobe dropped", pmem_read, 0);
        check("t6 addr reset", pmem_address, 0);

        // Randomized traffic: variable memory latency, spurious idle resps, occasional resets.
        mcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            si = i_pmem_resp; sd = d_pmem_resp;
            s = pmem_read | pmem_write; r = pmem_resp;
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            pmem_resp = 1'b0;
            pmem_rdata = rnd256();
            if (s && !r) begin
                if (mcnt == 0) begin
                    pmem_resp = 1'b1;
                    mcnt = $urandom_range(0, 3);
                end else begin
                    mcnt--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                pmem_resp = 1'b1;
            end
            if (i_pmem_read && si) i_pmem_read = $urandom_range(0, 1);
            else if (!i_pmem_read) i_pmem_read = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) i_pmem_address = $urandom;
            if ((d_pmem_read || d_pmem_write) && sd) begin
                d_pmem_read = 1'b0; d_pmem_write = 1'b0;
            end
            if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 15);
                d_pmem_write = (k < 7) || (k == 15);
                d_pmem_read  = (k >= 7);
            end
            if ($urandom_range(0, 3) == 0) d_pmem_address = $urandom;
            if ($urandom_range(0, 3) == 0) d_pmem_wdata = rnd256();
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
